// File: rtl/lt24_qsys_lcd_ctrl_pulse_out.sv
// LT24 control-line output port with one-shot timed pulse.
// Drives LCD reset / backlight / touch CS from a DATA register. A CTRL start
// inverts the masked bits for LEN clk cycles, then raises a sticky done flag
// that can interrupt the host when the pulse has finished.
module lt24_qsys_lcd_ctrl_pulse_out #(
   parameter int unsigned      WIDTH     = 1,
   parameter int unsigned      CNT_W     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   output logic [WIDTH-1:0] out_port
);

   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MASK_LSB = 8;

   localparam logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_LEN    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3);

   localparam int unsigned CTRL_IRQ_EN_BIT = 0;
   localparam int unsigned CTRL_START_BIT  = 1;
   localparam int unsigned CTRL_BUSY_BIT   = 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_PULSE = 1'b1
   } state_t;

   // architectural registers
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_data;
   logic [CNT_W-1:0]   r_len;
   logic [WIDTH-1:0]   r_mask;
   logic               r_irq_en;
   logic               r_done;
   logic [WIDTH-1:0]   r_out_port;
   logic [DATA_W-1:0]  r_readdata;

   // decoded bus strobes and next-state values
   logic               w_wr;
   logic               w_wr_data;
   logic               w_wr_len;
   logic               w_wr_ctrl;
   logic               w_wr_status;
   logic               w_start;
   logic               w_busy;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_set_done;
   logic [WIDTH-1:0]   w_out_nxt;
   logic [DATA_W-1:0]  w_rd_mux;
   logic               w_unused_wdata;

   // Avalon write decode
   assign w_wr        = chipselect & ~write_n;
   assign w_wr_data   = w_wr & (address == ADDR_DATA);
   assign w_wr_len    = w_wr & (address == ADDR_LEN);
   assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
   assign w_wr_status = w_wr & (address == ADDR_STATUS);
   assign w_start     = w_wr_ctrl & writedata[CTRL_START_BIT];
   assign w_busy      = (r_state == S_PULSE);

   // Not every writedata bit maps to a register field.
   assign w_unused_wdata = ^writedata;

   // FSM state and pulse counter register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next state, counter update and done-set request
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_set_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (r_len != '0) begin
                  w_state_nxt = S_PULSE;
                  w_cnt_nxt   = r_len;
               end else begin
                  // zero-length pulse completes immediately
                  w_set_done  = 1'b1;
               end
            end
         end
         S_PULSE: begin
            // a start seen here is ignored; cnt was loaded at pulse start
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_set_done  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // DATA and LEN registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_data <= RESET_VAL;
         r_len  <= '0;
      end else begin
         if (w_wr_data) begin
            r_data <= writedata[WIDTH-1:0];
         end
         if (w_wr_len) begin
            r_len <= writedata[CNT_W-1:0];
         end
      end
   end

   // CTRL fields latch on every CTRL write, busy or not
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_mask   <= '0;
         r_irq_en <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_mask   <= writedata[MASK_LSB +: WIDTH];
         r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
      end
   end

   // Sticky done flag; a completing pulse beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_done <= 1'b0;
      end else if (w_set_done) begin
         r_done <= 1'b1;
      end else if (w_wr_status) begin
         r_done <= 1'b0;
      end
   end

   // Output level: DATA when idle, DATA with masked bits inverted while pulsing
   always_comb begin
      w_out_nxt = r_data;
      if (w_busy) begin
         w_out_nxt = r_data ^ r_mask;
      end
   end

   // Registered output lines
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_out_port <= RESET_VAL;
      end else begin
         r_out_port <= w_out_nxt;
      end
   end

   // Read mux; unused bits read as zero
   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_DATA: begin
            w_rd_mux[WIDTH-1:0] = r_data;
         end
         ADDR_LEN: begin
            w_rd_mux[CNT_W-1:0] = r_len;
         end
         ADDR_CTRL: begin
            w_rd_mux[CTRL_IRQ_EN_BIT]     = r_irq_en;
            w_rd_mux[CTRL_BUSY_BIT]       = w_busy;
            w_rd_mux[MASK_LSB +: WIDTH]   = r_mask;
         end
         ADDR_STATUS: begin
            w_rd_mux[0] = r_done;
         end
      endcase
   end

   // Read data register, refreshed every cycle regardless of chipselect
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_mux;
      end
   end

   assign readdata = r_readdata;
   assign out_port = r_out_port;
   assign irq      = r_done & r_irq_en;

endmodule
